// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port byte memory between an instruction-fetch
// port (16-bit big-endian fetches, two memory reads) and a byte-wide data port.
//
// Parameters:
//   ADR_W      memory byte-address width
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   i_req, i_adr               fetch request (held until i_ack), byte address (bit 0 ignored)
//   i_data, i_ack              fetched instruction, one-cycle completion pulse
//   d_req, d_we, d_adr,        data request (held until d_ack), write enable,
//   d_wdata                    byte address, write byte
//   d_rdata, d_ack             read byte, one-cycle completion pulse
//   mem_adr, mem_wdata,        shared memory address, write byte, write strobe
//   mem_we, mem_rdata          read byte (valid one cycle after mem_adr)
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  when defined, a simultaneous fetch/data request goes to the
//                       requester not granted last; otherwise data always wins a tie.
//
// Outputs are decoded combinationally from the current state so that mem_adr is
// presented in the grant cycle and read data is visible alongside its ack.
module mem_arbiter #(
    parameter int unsigned ADR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [ADR_W-1:0] i_adr,
    output logic [15:0]      i_data,
    output logic             i_ack,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [ADR_W-1:0] d_adr,
    input  logic [7:0]       d_wdata,
    output logic [7:0]       d_rdata,
    output logic             d_ack,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    input  logic [7:0]       mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StIHi,
        StILo,
        StDRd,
        StDWr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] i_data_q, i_data_d;
    logic [7:0]  d_rdata_q, d_rdata_d;
    logic        fetch_wins;

    // Fetch halves: the word is always aligned, so an odd i_adr reads the same pair.
    logic [ADR_W-1:0] i_adr_hi, i_adr_lo;
    assign i_adr_hi = i_adr & ~ADR_W'(1);
    assign i_adr_lo = i_adr | ADR_W'(1);

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data was granted last; reset to data so the first tie goes to fetch.
    logic last_grant_q, last_grant_d;
    assign fetch_wins = i_req & (~d_req | last_grant_q);
`else
    assign fetch_wins = i_req & ~d_req;
`endif

    always_comb begin
        state_d   = state_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        i_data    = i_data_q;
        d_rdata   = d_rdata_q;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        mem_adr   = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_wins) begin
                    mem_adr = i_adr_hi;
                    state_d = StIHi;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b0;
`endif
                end else if (d_req) begin
                    mem_adr = d_adr;
                    if (d_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = d_wdata;
                        state_d   = StDWr;
                    end else begin
                        state_d = StDRd;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b1;
`endif
                end
            end
            StIHi: begin
                mem_adr  = i_adr_lo;
                i_data_d = {mem_rdata, i_data_q[7:0]};
                state_d  = StILo;
            end
            StILo: begin
                i_data_d = {i_data_q[15:8], mem_rdata};
                i_data   = i_data_d;
                i_ack    = 1'b1;
                state_d  = StIdle;
            end
            StDRd: begin
                d_rdata_d = mem_rdata;
                d_rdata   = mem_rdata;
                d_ack     = 1'b1;
                state_d   = StIdle;
            end
            StDWr: begin
                d_ack   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The cycle in which reset is sampled shows reset values on every output.
        if (reset) begin
            i_data    = 16'h0000;
            d_rdata   = 8'h00;
            i_ack     = 1'b0;
            d_ack     = 1'b0;
            mem_adr   = '0;
            mem_wdata = 8'h00;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            i_data_q  <= 16'h0000;
            d_rdata_q <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_adr, d_adr;
    logic [7:0]  d_wdata;
    logic [15:0] i_data;
    logic        i_ack, d_ack;
    logic [7:0]  d_rdata;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.ADR_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_adr     (i_adr),
        .i_data    (i_data),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_adr     (d_adr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory model, registered read; tb_load preloads bytes.
    logic [7:0]  mem [0:65535];
    logic        tb_load = 1'b0;
    logic [15:0] load_adr;
    logic [7:0]  load_val;

    always @(posedge clk) begin
        if (tb_load) mem[load_adr] <= load_val;
        else if (mem_we) mem[mem_adr] <= mem_wdata;
        mem_rdata <= mem[mem_adr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int both_ack = 0;

    always @(negedge clk) if (i_ack === 1'b1 && d_ack === 1'b1) both_ack++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] v);
        load_adr = a;
        load_val = v;
        tb_load  = 1'b1;
        @(posedge clk); #1;
        tb_load  = 1'b0;
    endtask

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [15:0] adr;
        logic [7:0]  wdata;
        logic [15:0] exp_data;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    function automatic vec_t mk(input logic f, input logic w, input logic [15:0] a,
                                input logic [7:0] wd, input logic [15:0] ed,
                                input int el, input int ew);
        vec_t v;
        v.is_fetch = f; v.we = w; v.adr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_lat = el; v.exp_we = ew;
        return v;
    endfunction

    // Called just after a posedge; cycle 0 is the grant cycle.
    task automatic run_txn(input vec_t v, output int lat, output int we_cnt,
                           output logic [15:0] got);
        bit done = 0;
        lat = -1; we_cnt = 0; got = 'x;
        if (v.is_fetch) begin
            i_req = 1'b1; i_adr = v.adr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_adr = v.adr; d_wdata = v.wdata;
        end
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (v.is_fetch ? i_ack : d_ack) begin
                lat  = c;
                got  = v.is_fetch ? i_data : {8'h00, d_rdata};
                done = 1;
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    vec_t        vecs [10];
    int          lat, we_cnt, acks;
    logic [15:0] got;
    logic [5:0]  order, exp_order;

    initial begin
        vecs[0] = mk(1, 0, 16'h0010, 8'h00, 16'h1234, 2, 0);
        vecs[1] = mk(0, 1, 16'h0300, 8'hA5, 16'h0000, 1, 1);
        vecs[2] = mk(0, 0, 16'h0300, 8'h00, 16'h00A5, 1, 0);
        vecs[3] = mk(1, 0, 16'hFFFF, 8'h00, 16'hABCD, 2, 0);
        vecs[4] = mk(1, 0, 16'hFFFE, 8'h00, 16'hABCD, 2, 0);
        vecs[5] = mk(1, 0, 16'h0203, 8'h00, 16'h5678, 2, 0);
        vecs[6] = mk(0, 1, 16'h0301, 8'h3C, 16'h0000, 1, 1);
        vecs[7] = mk(0, 0, 16'h0301, 8'h00, 16'h003C, 1, 0);
        vecs[8] = mk(0, 0, 16'h0010, 8'h00, 16'h0012, 1, 0);
        vecs[9] = mk(1, 0, 16'h0300, 8'h00, 16'hA53C, 2, 0);

        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_adr = 16'h0; d_adr = 16'h0; d_wdata = 8'h0;
        @(posedge clk); #1;
        load(16'h0010, 8'h12); load(16'h0011, 8'h34);
        load(16'hFFFE, 8'hAB); load(16'hFFFF, 8'hCD);
        load(16'h0202, 8'h56); load(16'h0203, 8'h78);

        // Reset-cycle outputs with both requests active.
        i_req = 1'b1; i_adr = 16'h1235;
        d_req = 1'b1; d_we = 1'b1; d_adr = 16'h4444; d_wdata = 8'hFF;
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_adr", 32'(mem_adr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        check("rst_data", {8'h0, i_data, d_rdata}, 32'h0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;

        for (int k = 0; k < 10; k++) begin
            run_txn(vecs[k], lat, we_cnt, got);
            check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("v%0d_we_pulses", k), 32'(we_cnt), 32'(vecs[k].exp_we));
            if (!vecs[k].we) check($sformatf("v%0d_data", k), 32'(got), 32'(vecs[k].exp_data));
            @(negedge clk);
            if (vecs[k].is_fetch) check($sformatf("v%0d_i_hold", k), 32'(i_data), 32'(vecs[k].exp_data));
            else if (!vecs[k].we) check($sformatf("v%0d_d_hold", k), 32'(d_rdata), 32'(vecs[k].exp_data));
            @(posedge clk); #1;
        end

        // Reset while in I_HI aborts the fetch without an ack.
        i_req = 1'b1; i_adr = 16'h0010;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_i_ack", 32'(i_ack), 32'h0);
        check("abort_i_data", 32'(i_data), 32'h0);
        check("abort_mem_adr", 32'(mem_adr), 32'h0);
        @(posedge clk); #1;
        i_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("post_rst_i_data", 32'(i_data), 32'h0);
        check("post_rst_d_rdata", 32'(d_rdata), 32'h0);
        check("post_rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        @(posedge clk); #1;
        run_txn(vecs[0], lat, we_cnt, got);
        check("refetch_latency", 32'(lat), 32'h2);
        check("refetch_data", 32'(got), 32'h1234);
        @(posedge clk); #1;

        // Tie with both requests held continuously.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        i_req = 1'b1; i_adr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_adr = 16'h0300;
        acks = 0; order = 6'h0;
        for (int c = 0; c < 30 && acks < 3; c++) begin
            @(negedge clk);
            if (i_ack) begin
                order = {order[3:0], 2'd1}; acks++;
                check("tie_i_data", 32'(i_data), 32'h1234);
            end else if (d_ack) begin
                order = {order[3:0], 2'd2}; acks++;
                check("tie_d_rdata", 32'(d_rdata), 32'hA5);
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = {2'd1, 2'd2, 2'd1};
`else
        exp_order = {2'd2, 2'd2, 2'd2};
`endif
        check("tie_ack_count", 32'(acks), 32'd3);
        check("tie_order", 32'(order), 32'(exp_order));
        repeat (2) @(posedge clk);
        check("never_both_acks", 32'(both_ack), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
